// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op-code encoding
// and the op-code field width.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational gate array: applies the selected bitwise operation across
// the operand pair and derives the zero and parity flags of the result.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  // Per-op bitwise function; no carries between bit lanes.
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NAND:  result = ~(a & b);
      OP_NOR:   result = ~(a | b);
      OP_XNOR:  result = ~(a ^ b);
      OP_NOTA:  result = ~a;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

  assign zero   = (result == '0);
  assign parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic unit top: valid/ready input, one registered output stage,
// and an accumulator that can stand in for operand A and absorb the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_value
);

  logic [WIDTH-1:0] acc_q;
  logic             accept_p0;
  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] result_p0;
  logic             zero_p0;
  logic             parity_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             zero_p1;
  logic             parity_p1;

  // Stage p0: handshake and operand selection. The output slot is free when
  // empty or draining this cycle, so a full pipe still takes one beat/cycle.
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign op_a_p0   = in_acc ? acc_q : in_a;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (in_op),
    .a      (op_a_p0),
    .b      (in_b),
    .result (result_p0),
    .zero   (zero_p0),
    .parity (parity_p0)
  );

  // Accumulator: a clear overrides a write-back from a coincident beat,
  // although that beat still computed from the pre-clear value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= ACC_INIT;
    end else if (acc_clr) begin
      acc_q <= ACC_INIT;
    end else if (accept_p0 && in_acc) begin
      acc_q <= result_p0;
    end
  end

  // Stage p1: output register; loads on accept, empties on drain, holds
  // data and flags while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      zero_p1   <= 1'b1;
      parity_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1    <= 1'b1;
      data_p1   <= result_p0;
      zero_p1   <= zero_p0;
      parity_p1 <= parity_p0;
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_zero   = zero_p1;
  assign out_parity = parity_p1;
  assign acc_value  = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: stimulus pushes expected results,
// a monitor pops and compares on every output transfer.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int         W    = 8;
  localparam logic [W-1:0] INIT = '0;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic         in_acc;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;
  logic         out_parity;
  logic [W-1:0] acc_value;

  logic_unit_pipe #(.WIDTH(W), .ACC_INIT(INIT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .in_a       (in_a),
    .in_b       (in_b),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .acc_value  (acc_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         parity;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_acc;
  int           ready_mode;   // 0: always ready, 1: random, 2: stalled
  int           n_cmp = 0;
  int           n_bad = 0;

  // Truth tables indexed by {a_bit, b_bit}, one per op code.
  logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                         4'b0001, 4'b1001, 4'b0011, 4'b1010};

  function automatic logic [W-1:0] ref_gate(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] r;
    tt = TT[op];
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic ref_par(logic [W-1:0] v);
    int cnt = 0;
    for (int i = 0; i < W; i++) if (v[i]) cnt++;
    return (cnt % 2) == 1;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshake rule, hold stability and scoreboard pops.
  initial begin
    bit           held = 0;
    logic [W-1:0] held_data;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held = 0;
      end else begin
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (held) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_data", out_data, held_data);
        end
        if (out_valid && out_ready) begin
          held = 0;
          if (sb.size() == 0) begin
            check("unexpected_output", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_zero", out_zero, e.zero);
            check("out_parity", out_parity, e.parity);
          end
        end else if (out_valid) begin
          held = 1;
          held_data = out_data;
        end else begin
          held = 0;
        end
      end
    end
  end

  // Issue one beat and keep it presented until accepted. Called at posedge+1.
  task automatic send(logic [2:0] op, bit acc, logic [W-1:0] a, logic [W-1:0] b,
                      bit clr, bit use_ov, logic [W-1:0] ov);
    logic [W-1:0] r;
    exp_t         e;
    int           t = 0;
    bit           done = 0;
    in_valid = 1'b1; in_op = op; in_acc = acc; in_a = a; in_b = b; acc_clr = clr;
    while (!done) begin
      @(negedge clk);
      check("acc_value", acc_value, m_acc);
      if (in_ready) begin
        r = ref_gate(op, acc ? m_acc : a, b);
        e.data   = use_ov ? ov : r;
        e.zero   = (e.data == '0);
        e.parity = ref_par(e.data);
        sb.push_back(e);
        if (acc) m_acc = r;
        done = 1;
      end else if (++t > 200) begin
        check("accept_timeout", 1'b0, 1'b1);
        done = 1;
      end
      if (clr) m_acc = INIT;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  // Idle cycles with invalid garbage on the bus; clr_mode 0 none, 1 all, 2 random.
  task automatic idle(int n, int clr_mode);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_op    = 3'($urandom);
      in_acc   = 1'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      acc_clr  = (clr_mode == 1) || (clr_mode == 2 && $urandom_range(0, 15) == 0);
      @(negedge clk);
      check("acc_value", acc_value, m_acc);
      if (acc_clr) m_acc = INIT;
      @(posedge clk); #1;
    end
    acc_clr = 1'b0;
  endtask

  task automatic check_acc_const(string name, logic [W-1:0] v);
    @(negedge clk);
    check(name, acc_value, v);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_ops [8] = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hA5};
    logic [W-1:0] exp_acc [3] = '{8'h12, 8'h26, 8'h70};
    logic [W-1:0] bs      [3] = '{8'h12, 8'h34, 8'h56};

    ready_mode = 0;
    rstn = 1'b0; in_valid = 1'b0; in_op = '0; in_acc = 1'b0;
    in_a = '0; in_b = '0; acc_clr = 1'b0;
    m_acc = INIT;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_zero", out_zero, 1'b1);
    check("rst_out_parity", out_parity, 1'b0);
    check("rst_acc", acc_value, INIT);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // All ops on fixed operands.
    for (int op = 0; op < 8; op++)
      send(3'(op), 1'b0, 8'hC3, 8'hA5, 1'b0, 1'b1, exp_ops[op]);
    idle(2, 0);

    // Accumulate XOR chain after a clear.
    idle(1, 1);
    for (int i = 0; i < 3; i++)
      send(3'(OP_XOR), 1'b1, 8'h00, bs[i], 1'b0, 1'b1, exp_acc[i]);
    check_acc_const("acc_chain", 8'h70);

    // Clear coincident with an accumulating OR beat.
    send(3'(OP_PASSB), 1'b1, 8'h00, 8'hF0, 1'b0, 1'b0, '0);
    check_acc_const("acc_loaded", 8'hF0);
    send(3'(OP_OR), 1'b1, 8'h00, 8'h0F, 1'b1, 1'b1, 8'hFF);
    check_acc_const("acc_clr_wins", INIT);
    drain();

    // Backpressure for three cycles inside a five-beat burst.
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(3'(OP_XOR), 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, '0);
      end
      begin
        repeat (2) @(posedge clk);
        ready_mode = 2;
        repeat (3) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain();

    // Randomized traffic.
    ready_mode = 1;
    for (int n = 0; n < 10000; n++) begin
      idle($urandom_range(0, 2) == 0 ? 1 : 0, 2);
      send(3'($urandom), 1'($urandom), W'($urandom), W'($urandom),
           $urandom_range(0, 15) == 0, 1'b0, '0);
    end
    ready_mode = 0;
    drain();

    // Reset while a result is stalled at the output.
    ready_mode = 2;
    @(posedge clk); #1;
    send(3'(OP_PASSB), 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, '0);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_out_zero", out_zero, 1'b1);
    check("midrst_acc", acc_value, INIT);
    sb.delete();
    m_acc = INIT;
    @(posedge clk); #1;
    rstn = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    send(3'(OP_NOTA), 1'b1, 8'h00, 8'h33, 1'b0, 1'b0, '0);
    send(3'(OP_AND), 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h30);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: applies one of eight selectable gate operations across a WIDTH-bit operand pair, or folds a stream of operands into an internal accumulator. One valid/ready input port, one registered valid/ready output port, with zero and parity flags per result. Serves as the datapath logic stage behind the single-bit gate primitives, for bus-wide masking, merging and checksum folding.

## Interface
- WIDTH, 8, operand/result width in bits (1..64)
- ACC_INIT, 0, accumulator value after reset and after acc_clr
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_op  in  3  operation code (see Operation)
- in_acc  in  1  0: operand A = in_a; 1: operand A = accumulator, result written back to accumulator
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- acc_clr  in  1  synchronous accumulator clear to ACC_INIT
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  result
- out_zero  out  1  out_data == 0
- out_parity  out  1  XOR-reduction of out_data
- acc_value  out  WIDTH  current accumulator contents

## Operation
- Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS B; all bitwise across WIDTH, no carries.
- Beat accepted when in_valid && in_ready; result computed from A/B/op of that beat.
- in_acc=1: A taken as accumulator value before the beat; accumulator <= result on accept. in_acc=0: accumulator untouched, in_a used.
- acc_clr: accumulator <= ACC_INIT next edge. acc_clr with a simultaneous accepted in_acc=1 beat: the beat uses the pre-clear accumulator for its result; clear wins the write (accumulator = ACC_INIT afterwards).
- out_zero/out_parity registered alongside out_data, always consistent with it.
- Output register holds data/flags stable while out_valid && !out_ready.
- No beats dropped, duplicated or reordered.

## Timing
- Reset (rstn low, async): out_valid=0, out_data=0, out_zero=1, out_parity=0, accumulator=ACC_INIT; in_ready=1 after reset is released.
- Latency: 1 cycle, accept at edge N -> out_valid with result after edge N.
- in_ready = !out_valid || out_ready (combinational from out_ready; no in_valid dependence).
- Full throughput: one beat per cycle with out_ready held high.
- Backpressure: out_valid && !out_ready -> in_ready=0, no accept, accumulator frozen.
- Simultaneous output drain and input accept in the same cycle: new result replaces old at the edge, out_valid stays 1.
- Back-to-back in_acc beats: beat N+1 sees accumulator written by beat N (no hazard bubble).
- Reset asserted mid-stream: pending result discarded, all state to reset values immediately.
- in_valid may drop without handshake; payload must be stable only while in_valid && !in_ready.

## Structure
- Package logic_unit_pkg: op-code enum (OP_AND..OP_PASSB), op width constant = 3.
- Sub-module logic_unit_core: purely combinational, WIDTH-parametrised, op/A/B -> result, zero, parity; instantiated once.
- Top holds the accumulator, the output register and the handshake logic.

## Test plan
- Reset: rstn low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_zero=1, acc_value=ACC_INIT immediately.
- All ops, WIDTH=8, A=0xC3, B=0xA5, out_ready=1 -> 0x81, 0xE7, 0x66, 0x7E, 0x18, 0x99, 0x3C, 0xA5, one cycle after each accept; parity/zero match.
- Accumulate: acc_clr, then XOR beats in_acc=1 with B=0x12, 0x34, 0x56 back-to-back -> out_data 0x12, 0x26, 0x70; acc_value=0x70.
- Backpressure: out_ready low 3 cycles during a 5-beat burst -> in_ready low, out_data stable, accumulator frozen, all 5 results delivered in order.
- acc_clr coincident with in_acc OR beat B=0x0F, acc=0xF0 -> out_data=0xFF, acc_value=ACC_INIT afterwards.
- Random ops/operands, random valid/ready, 10k beats, scoreboard vs reference model -> zero mismatches; WIDTH=1 and WIDTH=64 builds pass.
